// File: rtl/order_book_cmd_issuer.sv
// Front-end sequencer for the tree-based order book. Buffers decoded feed
// messages in a small FIFO, issues them one at a time as single-cycle
// commands, waits for the book to settle, then reports top-of-book changes.
module order_book_cmd_issuer #(
    parameter int         PRICE_W       = 7,
    parameter int         QTY_W         = 16,
    parameter int         ORDER_W       = 10,
    parameter int         FIFO_DEPTH    = 4,
    parameter logic [2:0] ADD_ORDER     = 3'd1,
    parameter logic [2:0] CANCEL_ORDER  = 3'd2,
    parameter logic [2:0] EXECUTE_ORDER = 3'd3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               msg_valid,
    output logic               msg_ready,
    input  logic [2:0]         msg_type,
    input  logic [ORDER_W-1:0] msg_order_id,
    input  logic [PRICE_W-1:0] msg_price,
    input  logic [QTY_W-1:0]   msg_qty,
    output logic               start_book,
    output logic [2:0]         request,
    output logic [ORDER_W-1:0] add_order_id,
    output logic [PRICE_W-1:0] add_price,
    output logic [QTY_W-1:0]   add_qty,
    output logic [ORDER_W-1:0] order_id,
    output logic [QTY_W-1:0]   quantity,
    input  logic               is_busy_i,
    input  logic               price_valid_i,
    input  logic [PRICE_W-1:0] best_price_i,
    input  logic               best_price_valid_i,
    output logic               bbo_valid,
    output logic [PRICE_W-1:0] bbo_price,
    output logic               bbo_present,
    output logic [15:0]        drop_cnt,
    output logic [15:0]        issued_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(FIFO_DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE  = 3'd1;
    localparam logic [2:0] GUARD  = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] REPORT = 3'd4;

    logic [2:0]         f_type  [FIFO_DEPTH];
    logic [ORDER_W-1:0] f_id    [FIFO_DEPTH];
    logic [PRICE_W-1:0] f_price [FIFO_DEPTH];
    logic [QTY_W-1:0]   f_qty   [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;

    logic [2:0]         state, next_state;
    logic [2:0]         cmd_type;
    logic [ORDER_W-1:0] cmd_id;
    logic [PRICE_W-1:0] cmd_price;
    logic [QTY_W-1:0]   cmd_qty;

    logic [PRICE_W-1:0] bbo_price_q;
    logic               bbo_present_q;

    logic msg_ok, accept, push, drop, pop, is_add, changed;
    logic [PRICE_W-1:0] new_price;

    // Malformed messages complete the handshake but never take a slot.
    assign msg_ready = (count != FULL);
    assign msg_ok    = (msg_type == ADD_ORDER && msg_qty != '0) ||
                       msg_type == CANCEL_ORDER || msg_type == EXECUTE_ORDER;
    assign accept    = msg_valid && msg_ready;
    assign push      = accept && msg_ok;
    assign drop      = accept && !msg_ok;
    assign pop       = (state == IDLE) && (count != '0) && !is_busy_i;

    // FIFO storage: data only, no reset needed.
    always_ff @(posedge clk_in) begin
        if (push) begin
            f_type[wr_ptr]  <= msg_type;
            f_id[wr_ptr]    <= msg_order_id;
            f_price[wr_ptr] <= msg_price;
            f_qty[wr_ptr]   <= msg_qty;
        end
    end

    // FIFO pointers and occupancy; simultaneous push/pop leaves count alone.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Next-state logic for the one-outstanding-command sequencer.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pop) next_state = ISSUE;
            ISSUE:   next_state = GUARD;
            GUARD:   next_state = WAIT;   // book's price_valid is stale here
            WAIT:    if (price_valid_i && !is_busy_i) next_state = REPORT;
            REPORT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, command register, counters and last-reported top of book.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= IDLE;
            cmd_type      <= '0;
            cmd_id        <= '0;
            cmd_price     <= '0;
            cmd_qty       <= '0;
            drop_cnt      <= '0;
            issued_cnt    <= '0;
            bbo_price_q   <= '0;
            bbo_present_q <= 1'b0;
        end else begin
            state <= next_state;
            if (pop) begin
                cmd_type  <= f_type[rd_ptr];
                cmd_id    <= f_id[rd_ptr];
                cmd_price <= f_price[rd_ptr];
                cmd_qty   <= f_qty[rd_ptr];
            end
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            if (state == ISSUE) issued_cnt <= issued_cnt + 16'd1;
            if (bbo_valid) begin
                bbo_price_q   <= new_price;
                bbo_present_q <= best_price_valid_i;
            end
        end
    end

    // Command outputs are zero except in the single ISSUE cycle; since the
    // state register resets asynchronously, start_book drops with rst_in.
    assign start_book   = (state == ISSUE);
    assign is_add       = (cmd_type == ADD_ORDER);
    assign request      = start_book ? cmd_type : 3'd0;
    assign add_order_id = (start_book && is_add)  ? cmd_id    : '0;
    assign add_price    = (start_book && is_add)  ? cmd_price : '0;
    assign add_qty      = (start_book && is_add)  ? cmd_qty   : '0;
    assign order_id     = (start_book && !is_add) ? cmd_id    : '0;
    assign quantity     = (start_book && !is_add) ? cmd_qty   : '0;

    // An empty book reports price 0 so stale prices never cause an event.
    // During the event cycle the outputs already show the new top of book.
    assign new_price   = best_price_valid_i ? best_price_i : '0;
    assign changed     = {best_price_valid_i, new_price} != {bbo_present_q, bbo_price_q};
    assign bbo_valid   = (state == REPORT) && changed;
    assign bbo_price   = bbo_valid ? new_price : bbo_price_q;
    assign bbo_present = bbo_valid ? best_price_valid_i : bbo_present_q;

endmodule

// File: doc/order_book_cmd_issuer.md
# order_book_cmd_issuer

Front-end sequencer that drives the tree-based order book's request port. It accepts decoded feed messages over a valid/ready stream and buffers them in a small FIFO. It issues each message to the book as a single-cycle `start_book` command, then waits for the book's price tree to settle. It reports top-of-book changes as one-cycle `bbo_valid` events to the strategy side.

## Interface
- `PRICE_W`, 7: price width; the book has 2^PRICE_W levels.
- `QTY_W`, 16: quantity width.
- `ORDER_W`, 10: order id width.
- `FIFO_DEPTH`, 4: message buffer entries; must be a power of 2.
- `ADD_ORDER`, 3'd1: request code for an add.
- `CANCEL_ORDER`, 3'd2: request code for a cancel.
- `EXECUTE_ORDER`, 3'd3: request code for an execute.

Ports:
- `clk_in` in 1: clock; the block has one clock.
- `rst_in` in 1: reset, asynchronous and active-high.
- `msg_valid` in 1: upstream message valid.
- `msg_ready` out 1: FIFO can accept a message.
- `msg_type` in 3: request code.
- `msg_order_id` in ORDER_W: order id.
- `msg_price` in PRICE_W: price; used by ADD only.
- `msg_qty` in QTY_W: quantity.
- `start_book` out 1: one-cycle command strobe to the book.
- `request` out 3: command code.
- `add_order_id` out ORDER_W: book_entry order_id field; packed by the parent.
- `add_price` out PRICE_W: book_entry price field.
- `add_qty` out QTY_W: book_entry quantity field.
- `order_id` out ORDER_W: cancel/execute target.
- `quantity` out QTY_W: execute quantity.
- `is_busy_i` in 1: book busy.
- `price_valid_i` in 1: book price tree settled.
- `best_price_i` in PRICE_W: book best price.
- `best_price_valid_i` in 1: book non-empty.
- `bbo_valid` out 1: one-cycle top-of-book change event.
- `bbo_price` out PRICE_W: reported best price.
- `bbo_present` out 1: reported book non-empty.
- `drop_cnt` out 16: dropped-message counter, saturating.
- `issued_cnt` out 16: issued-command counter, wrapping.

## Operation
- FIFO:
  - `msg_ready = (count != FIFO_DEPTH)`.
  - A message is pushed when `msg_valid && msg_ready`.
  - Push and pop may occur in the same cycle, so count is unchanged.
- Filter at push: a message is not stored if either condition holds:
  - `msg_type` is not one of the three codes;
  - `msg_type==ADD_ORDER` with `msg_qty==0`.
  - The handshake still completes and `drop_cnt` increments, saturating at 16'hFFFF.
- FSM states:
  - IDLE: when the FIFO is non-empty and `!is_busy_i`, pop the head into the command register and go to ISSUE.
  - ISSUE: drive `start_book=1` and all command fields from the command register for exactly one cycle; `issued_cnt++`; go to GUARD.
  - GUARD: one cycle, ignoring `price_valid_i`, because the book drops it the cycle after `start_book`; go to WAIT.
  - WAIT: stay until `price_valid_i && !is_busy_i`; then go to REPORT.
  - REPORT: compare `{best_price_valid_i, best_price_i}` against the last reported `{bbo_present, bbo_price}`.
    - If they differ, update the registers and pulse `bbo_valid`.
    - If `best_price_valid_i==0`, `bbo_price` is forced to 0 in the comparison and the update.
    - Always return to IDLE.
- Field driving:
  - ADD: `add_*` carry the message; `order_id`/`quantity` are 0.
  - CANCEL/EXECUTE: `order_id` = id, `quantity` = qty; `add_*` are 0.
  - When `start_book==0`, all command outputs are 0.
- Only one command is outstanding at a time; no command is issued while `is_busy_i` is high.

## Timing
- Reset values: `msg_ready=1` (FIFO empty), `start_book=0`, all command fields 0, `bbo_valid=0`, `bbo_price=0`, `bbo_present=0`, both counters 0, FSM in IDLE.
- Reset mid-operation: FIFO contents are discarded and the in-flight command is abandoned. `start_book` falls asynchronously with `rst_in`. No `bbo_valid` is emitted for the abandoned command.
- Latency (book idle, FIFO empty):
  - message accepted at edge 0;
  - pop at edge 1;
  - `start_book` high in cycle 2;
  - REPORT occurs no earlier than 2 cycles after ISSUE plus the book's settle time;
  - `bbo_valid` is high during the REPORT cycle.
- Throughput: one command per (4 + settle) cycles; the FIFO absorbs bursts of FIFO_DEPTH.
- `bbo_valid` pulses at most once per issued command and is never asserted outside REPORT.
- A dropped message does not occupy a FIFO slot and never reaches the book.

## Test plan
- Reset then ADD (id 5, price 40, qty 10), with `best_price_i=40` and `best_price_valid_i=1` once settled:
  - `start_book` pulses once, with `request=1`, `add_price=40`, `add_qty=10`;
  - `bbo_valid` pulses with `bbo_price=40`, `bbo_present=1`;
  - `issued_cnt=1`.
- ADD at price 30 while best stays 40: command issued; no `bbo_valid`.
- CANCEL id 5, book then reports empty:
  - `request=2`, `order_id=5`, `add_*=0`;
  - `bbo_valid` pulses with `bbo_present=0`, `bbo_price=0`.
- Burst of 6 messages back-to-back with `is_busy_i` held high:
  - 4 are accepted and `msg_ready` drops to 0;
  - no `start_book` occurs until `is_busy_i` falls;
  - then all accepted commands issue in order, each separated by a full GUARD/WAIT.
- Messages with `msg_type=3'd7`, and an ADD with qty 0:
  - both are accepted (`msg_ready` stays 1);
  - `drop_cnt=2`; no `start_book`.
- Assert `rst_in` in the cycle `start_book` is high:
  - `start_book` is 0 immediately;
  - after release, all outputs are at reset values and the FIFO is empty.
